// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default geometry and flat-bus slice helper
package regfile_pkg;
    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/regfile_n_if.sv
// regfile_n_if: write/read/clear bus of the multi-port register file
interface regfile_n_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
);
    logic                   we;
    logic [AW-1:0]          wsel;
    logic [WIDTH-1:0]       d;
    logic [AW-1:0]          rsel0;
    logic [AW-1:0]          rsel1;
    logic [WIDTH-1:0]       q0;
    logic [WIDTH-1:0]       q1;
    logic                   clr_req;
    logic                   busy;
    logic                   done;
    logic                   wr_err;
    logic [DEPTH*WIDTH-1:0] r_out;
    modport master (output we, wsel, d, rsel0, rsel1, clr_req,
                    input q0, q1, busy, done, wr_err, r_out);
    modport slave  (input we, wsel, d, rsel0, rsel1, clr_req,
                    output q0, q1, busy, done, wr_err, r_out);
endinterface

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear sweep FSM, one register index per cycle while busy
module regfile_clr_seq import regfile_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          ck,
    input  logic          res,
    input  logic          clr_req,
    output logic          busy,
    output logic          done,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_idx
);
    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_idx, w_idx_nx;
    logic          r_done, w_done_nx, w_last;
    always_ff @(posedge ck) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_done  <= w_done_nx;
        end
    end
    // done is registered, so it is predicted from the next state
    always_comb begin
        w_last     = int'(r_idx) == DEPTH - 1;
        w_state_nx = r_state;
        w_idx_nx   = '0;
        if (r_state == ST_SWEEP) begin
            w_state_nx = w_last ? ST_IDLE : ST_SWEEP;
            w_idx_nx   = w_last ? '0 : r_idx + 1'b1;
        end else if (clr_req) begin
            w_state_nx = ST_SWEEP;
        end
        w_done_nx = (w_state_nx == ST_SWEEP) && (int'(w_idx_nx) == DEPTH - 1);
    end
    assign busy      = r_state == ST_SWEEP;
    assign sweep_we  = busy;
    assign sweep_idx = r_idx;
    assign done      = r_done;
endmodule

// File: rtl/regfile_n.sv
// regfile_n: parametrised 1W/2R register file with optional bypass and clear sweep
module regfile_n import regfile_pkg::*; #(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter bit               BYPASS  = 1'b0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input logic        ck,
    input logic        res,
    regfile_n_if.slave bus
);
    logic [WIDTH-1:0]         r_mem [DEPTH];
    logic                     r_wr_err;
    logic                     w_busy, w_sweep_we, w_wr_ok;
    logic [$clog2(DEPTH)-1:0] w_sweep_idx;
    regfile_clr_seq #(.DEPTH(DEPTH)) u_clr (
        .ck        (ck),
        .res       (res),
        .clr_req   (bus.clr_req),
        .busy      (w_busy),
        .done      (bus.done),
        .sweep_we  (w_sweep_we),
        .sweep_idx (w_sweep_idx)
    );
    assign w_wr_ok = bus.we && !w_busy && (int'(bus.wsel) < DEPTH);
    always_ff @(posedge ck) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_sweep_we) r_mem[w_sweep_idx] <= CLR_VAL;
            else if (w_wr_ok) r_mem[bus.wsel] <= bus.d;
            r_wr_err <= bus.we && w_busy;
        end
    end
    // w_wr_ok already excludes the sweep and out-of-range selects, so bypass is never taken then
    assign bus.q0 = (BYPASS && w_wr_ok && bus.rsel0 == bus.wsel) ? bus.d :
                    (int'(bus.rsel0) < DEPTH) ? r_mem[bus.rsel0] : '0;
    assign bus.q1 = (BYPASS && w_wr_ok && bus.rsel1 == bus.wsel) ? bus.d :
                    (int'(bus.rsel1) < DEPTH) ? r_mem[bus.rsel1] : '0;
    assign bus.busy   = w_busy;
    assign bus.wr_err = r_wr_err;
    for (genvar i = 0; i < DEPTH; i++) begin : g_out
        assign bus.r_out[slice_lo(i, WIDTH) +: WIDTH] = r_mem[i];
    end
endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n: table vectors and randomized traffic against a per-rule reference model
module tb_regfile_n;
    logic ck = 1'b0;
    logic res_a, res_c;
    int   n_chk = 0;
    int   n_err = 0;

    initial forever #5 ck = ~ck;

    regfile_n_if #(.WIDTH(16), .DEPTH(4)) ifa ();
    regfile_n_if #(.WIDTH(16), .DEPTH(4)) ifb ();
    regfile_n_if #(.WIDTH(8),  .DEPTH(5)) ifc ();

    assign ifb.we      = ifa.we;
    assign ifb.wsel    = ifa.wsel;
    assign ifb.d       = ifa.d;
    assign ifb.rsel0   = ifa.rsel0;
    assign ifb.rsel1   = ifa.rsel1;
    assign ifb.clr_req = ifa.clr_req;

    regfile_n #(.WIDTH(16), .DEPTH(4), .BYPASS(1'b0), .CLR_VAL(16'hFFFF)) dut_a (.ck(ck), .res(res_a), .bus(ifa.slave));
    regfile_n #(.WIDTH(16), .DEPTH(4), .BYPASS(1'b1), .CLR_VAL(16'hFFFF)) dut_b (.ck(ck), .res(res_a), .bus(ifb.slave));
    regfile_n #(.WIDTH(8),  .DEPTH(5), .BYPASS(1'b0), .CLR_VAL(8'h5A))    dut_c (.ck(ck), .res(res_c), .bus(ifc.slave));

    // reference model: config 0 = 4x16 (a and b), config 1 = 5x8 (c)
    logic [15:0] mm [2][5];
    int          pos [2] = '{-1, -1};
    bit          e_done [2];
    bit          e_err [2];

    function automatic int dep(int c);
        return c != 0 ? 5 : 4;
    endfunction

    function automatic logic [15:0] cv(int c);
        return c != 0 ? 16'h005A : 16'hFFFF;
    endfunction

    task automatic model_edge(int c, logic rs, logic w, int ws, logic [15:0] dd, logic cr);
        if (rs) begin
            for (int i = 0; i < 5; i++) mm[c][i] = '0;
            pos[c]   = -1;
            e_err[c] = 1'b0;
        end else begin
            e_err[c] = w && pos[c] >= 0;
            if (pos[c] >= 0) begin
                mm[c][pos[c]] = cv(c);
                pos[c] = (pos[c] == dep(c) - 1) ? -1 : pos[c] + 1;
            end else begin
                if (w && ws < dep(c)) mm[c][ws] = dd;
                if (cr) pos[c] = 0;
            end
        end
        e_done[c] = pos[c] == dep(c) - 1;
    endtask

    always @(posedge ck) begin
        model_edge(0, res_a, ifa.we, int'(ifa.wsel), ifa.d, ifa.clr_req);
        model_edge(1, res_c, ifc.we, int'(ifc.wsel), 16'(ifc.d), ifc.clr_req);
    end

    function automatic logic [15:0] exp_q(int c, bit byp, int rs, logic w, int ws, logic [15:0] dd);
        if (rs >= dep(c)) return '0;
        if (byp && w && pos[c] < 0 && ws < dep(c) && rs == ws) return dd;
        return mm[c][rs];
    endfunction

    function automatic logic [79:0] exp_ro(int c);
        logic [79:0] ro = '0;
        for (int i = 0; i < dep(c); i++) ro = ro | (80'(mm[c][i]) << (i * (c != 0 ? 8 : 16)));
        return ro;
    endfunction

    task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_q0", 80'(ifa.q0), 80'(exp_q(0, 0, int'(ifa.rsel0), ifa.we, int'(ifa.wsel), ifa.d)));
        chk("a_q1", 80'(ifa.q1), 80'(exp_q(0, 0, int'(ifa.rsel1), ifa.we, int'(ifa.wsel), ifa.d)));
        chk("b_q0", 80'(ifb.q0), 80'(exp_q(0, 1, int'(ifa.rsel0), ifa.we, int'(ifa.wsel), ifa.d)));
        chk("b_q1", 80'(ifb.q1), 80'(exp_q(0, 1, int'(ifa.rsel1), ifa.we, int'(ifa.wsel), ifa.d)));
        chk("a_rout", 80'(ifa.r_out), exp_ro(0));
        chk("b_rout", 80'(ifb.r_out), exp_ro(0));
        chk("a_flags", {77'd0, ifa.busy, ifa.done, ifa.wr_err}, {77'd0, pos[0] >= 0, e_done[0], e_err[0]});
        chk("b_flags", {77'd0, ifb.busy, ifb.done, ifb.wr_err}, {77'd0, pos[0] >= 0, e_done[0], e_err[0]});
        chk("c_q0", 80'(ifc.q0), 80'(exp_q(1, 0, int'(ifc.rsel0), ifc.we, int'(ifc.wsel), 16'(ifc.d))));
        chk("c_q1", 80'(ifc.q1), 80'(exp_q(1, 0, int'(ifc.rsel1), ifc.we, int'(ifc.wsel), 16'(ifc.d))));
        chk("c_rout", 80'(ifc.r_out), exp_ro(1));
        chk("c_flags", {77'd0, ifc.busy, ifc.done, ifc.wr_err}, {77'd0, pos[1] >= 0, e_done[1], e_err[1]});
    endtask

    typedef struct {
        logic        res, we;
        logic [1:0]  wsel;
        logic [15:0] d;
        logic [1:0]  rsel0, rsel1;
        logic        clr;
        logic [15:0] q0, q1, q1b;
        logic        busy, done, err;
    } vec_t;

    function automatic vec_t mk(int rs, int w, int ws, int dd, int r0, int r1, int cr,
                                int q0, int q1, int q1b, int b, int dn, int er);
        vec_t v;
        v.res = 1'(rs); v.we = 1'(w); v.wsel = 2'(ws); v.d = 16'(dd);
        v.rsel0 = 2'(r0); v.rsel1 = 2'(r1); v.clr = 1'(cr);
        v.q0 = 16'(q0); v.q1 = 16'(q1); v.q1b = 16'(q1b);
        v.busy = 1'(b); v.done = 1'(dn); v.err = 1'(er);
        return v;
    endfunction

    vec_t tbl [25];

    initial begin
        int nb, dn_at, dn_cnt;
        tbl[0]  = mk(0, 1, 0, 'h4c55, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 2, 'h0007, 0, 2, 0, 'h4c55, 0, 'h0007, 0, 0, 0);
        tbl[2]  = mk(0, 1, 2, 'h1234, 0, 2, 0, 'h4c55, 'h0007, 'h1234, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 2, 2, 0, 'h1234, 'h1234, 'h1234, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 3, 0, 'h4c55, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 1, 2, 3, 1, 2, 0, 2, 'h1234, 3, 0, 0, 0);
        tbl[7]  = mk(0, 1, 3, 4, 2, 3, 0, 3, 0, 4, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 3, 0, 1, 4, 1, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
        tbl[10] = mk(0, 1, 3, 'hAAAA, 0, 3, 0, 'hFFFF, 4, 4, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 3, 1, 'hFFFF, 4, 4, 1, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 2, 3, 0, 'hFFFF, 4, 4, 1, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 3, 0, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 3, 1, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 3, 1, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 3, 0, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 3, 0, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 0);
        tbl[18] = mk(0, 1, 0, 'h1111, 0, 3, 1, 'hFFFF, 'hFFFF, 'hFFFF, 1, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 3, 1, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 3, 0, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 0);
        tbl[21] = mk(1, 1, 0, 'h5555, 0, 3, 1, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 1, 1, 'hBEEF, 1, 1, 0, 0, 0, 'hBEEF, 0, 0, 0);

        res_a = 1'b1; res_c = 1'b1;
        ifa.we = 0; ifa.wsel = 0; ifa.d = 0; ifa.rsel0 = 0; ifa.rsel1 = 0; ifa.clr_req = 0;
        ifc.we = 0; ifc.wsel = 0; ifc.d = 0; ifc.rsel0 = 0; ifc.rsel1 = 0; ifc.clr_req = 0;
        @(negedge ck);
        res_a = 1'b0; res_c = 1'b0;
        #1;
        chk("rst_a", {ifa.r_out, ifa.busy, ifa.done, ifa.wr_err}, '0);
        chk("rst_c", {ifc.r_out, ifc.busy, ifc.done, ifc.wr_err}, '0);
        check_all();

        for (int i = 0; i < 25; i++) begin
            @(negedge ck);
            res_a = tbl[i].res; ifa.we = tbl[i].we; ifa.wsel = tbl[i].wsel; ifa.d = tbl[i].d;
            ifa.rsel0 = tbl[i].rsel0; ifa.rsel1 = tbl[i].rsel1; ifa.clr_req = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_q0", i), 80'(ifa.q0), 80'(tbl[i].q0));
            chk($sformatf("tbl%0d_q1", i), 80'(ifa.q1), 80'(tbl[i].q1));
            chk($sformatf("tbl%0d_q1b", i), 80'(ifb.q1), 80'(tbl[i].q1b));
            chk($sformatf("tbl%0d_flags", i), {77'd0, ifa.busy, ifa.done, ifa.wr_err},
                {77'd0, tbl[i].busy, tbl[i].done, tbl[i].err});
            check_all();
        end

        @(negedge ck);
        res_a = 0; ifa.we = 0; ifa.clr_req = 0;
        ifc.we = 1; ifc.wsel = 3'd5; ifc.d = 8'hAB; ifc.rsel0 = 3'd7; ifc.rsel1 = 3'd0;
        #1;
        chk("c_q0_oob", 80'(ifc.q0), 80'h0);
        check_all();
        @(negedge ck);
        ifc.we = 1; ifc.wsel = 3'd4; ifc.d = 8'h33;
        #1;
        chk("c_drop", 80'(ifc.r_out), 80'h0);
        check_all();
        @(negedge ck);
        ifc.we = 0; ifc.clr_req = 1; ifc.rsel0 = 3'd4;
        #1;
        chk("c_w4", 80'(ifc.q0), 80'h33);
        check_all();
        nb = 0; dn_at = -1; dn_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ck);
            ifc.clr_req = 0;
            #1;
            check_all();
            if (ifc.busy) nb++;
            if (ifc.done) begin dn_cnt++; dn_at = nb; end
        end
        chk("c_busy_len", 80'(nb), 80'd5);
        chk("c_done_pos", 80'(dn_at), 80'd5);
        chk("c_done_cnt", 80'(dn_cnt), 80'd1);
        chk("c_swept", 80'(ifc.r_out), 80'h5A5A5A5A5A);

        for (int k = 0; k < 600; k++) begin
            @(negedge ck);
            res_a = $urandom_range(0, 63) == 0;
            ifa.we = 1'($urandom); ifa.wsel = 2'($urandom); ifa.d = 16'($urandom);
            ifa.rsel0 = 2'($urandom); ifa.rsel1 = 2'($urandom);
            ifa.clr_req = $urandom_range(0, 9) == 0;
            res_c = $urandom_range(0, 63) == 0;
            ifc.we = 1'($urandom); ifc.wsel = 3'($urandom); ifc.d = 8'($urandom);
            ifc.rsel0 = 3'($urandom); ifc.rsel1 = 3'($urandom);
            ifc.clr_req = $urandom_range(0, 9) == 0;
            #1;
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_n.md
Name: regfile_n

Overview:
- Parametrised multi-port register file; successor to the fixed 4x16 single-read register file in the calculator datapath.
- Provides one write port and two independent combinational read ports, a flat debug view of all registers, and optional write-to-read bypass.
- Includes a sequenced clear engine that writes CLR_VAL into every register, one register per cycle.
- Sits between the operand decoder and the ALU, feeding both ALU operands in the same cycle.

Parameters:
- WIDTH, 16, bits per register (>=1).
- DEPTH, 4, number of registers (>=2; non-power-of-two allowed).
- AW, $clog2(DEPTH), select width (derived; not overridden by users).
- BYPASS, 0, 1 = a read of the register being written returns d in the same cycle.
- CLR_VAL, 0, WIDTH-bit value written by the clear sweep.

Ports:
- ck  in  1  clock; all state updates on rising edge.
- res  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- wsel  in  AW  write register index.
- d  in  WIDTH  write data.
- rsel0  in  AW  read port 0 index.
- rsel1  in  AW  read port 1 index.
- q0  out  WIDTH  read port 0 data (combinational).
- q1  out  WIDTH  read port 1 data (combinational).
- clr_req  in  1  start clear sweep (level sampled each cycle).
- busy  out  1  clear sweep in progress.
- done  out  1  one-cycle pulse on the last sweep write.
- wr_err  out  1  one-cycle pulse, one cycle after a write rejected during the sweep.
- r_out  out  DEPTH*WIDTH  all registers flattened; register i at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (res=1 at an edge): all registers = 0 (not CLR_VAL); busy=0, done=0, wr_err=0; sweep counter=0.
  - res has priority over every other input.
  - res asserted mid-sweep aborts the sweep immediately.
- Write: when we=1, busy=0 and wsel<DEPTH, reg[wsel]<=d at the edge; visible on q0/q1/r_out after that edge.
  - wsel>=DEPTH: write silently dropped; no wr_err.
- Read: q0=reg[rsel0] and q1=reg[rsel1], combinational; rsel>=DEPTH returns 0.
  - BYPASS=1 and we=1, busy=0, rsel==wsel<DEPTH: qN=d in the same cycle.
  - BYPASS=0: qN shows the old value until the edge.
  - Both ports may select the same register.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 -> SWEEP with idx=0; busy=1 from the next cycle. A write in the clr_req cycle itself is still performed.
  - SWEEP: each cycle, reg[idx]<=CLR_VAL and idx++. At idx==DEPTH-1, done=1 for that cycle, then -> IDLE with busy=0 next cycle. Busy lasts exactly DEPTH cycles.
  - clr_req during SWEEP: ignored; no restart, no queueing.
  - clr_req held high after done: starts a new sweep on the following IDLE cycle.
- Writes during SWEEP:
  - Array write suppressed.
  - wr_err=1 on the following cycle, one pulse per rejected cycle.
  - A rejected write in the final sweep cycle still raises wr_err one cycle later, while IDLE.
- Reads during SWEEP: return current contents; no bypass.
- done and wr_err are registered; busy is a registered FSM output.

Decomposition:
- Package regfile_pkg holds:
  - state encoding (ST_IDLE, ST_SWEEP)
  - default WIDTH/DEPTH constants
  - a function returning the flat-bus slice offset
- Sub-module regfile_clr_seq implements the sweep FSM and counter.
  - Inputs: ck, res, clr_req.
  - Outputs: busy, done, sweep_we, sweep_idx.
  - Parameter: DEPTH.
- The storage array, read muxes, bypass and wr_err logic stay in regfile_n.

Test Plan (WIDTH=16, DEPTH=4 unless noted):
- Reset, then write 16'h4c55 to wsel=0; next cycle rsel0=0 -> q0=16'h4c55, r_out[15:0]=16'h4c55, other slices 0.
- Same-cycle read/write, we=1, wsel=2, d=16'h1234, rsel1=2, reg2 previously 16'h0007:
  - BYPASS=0 -> q1=16'h0007 before the edge, 16'h1234 after.
  - BYPASS=1 -> q1=16'h1234 immediately.
- Registers preloaded 1,2,3,4, CLR_VAL=16'hFFFF, pulse clr_req:
  - busy high for exactly 4 cycles; done high on the 4th.
  - r_out fills 16'hFFFF from index 0 upward, one register per cycle.
  - busy=0 on the 5th cycle.
- During the sweep, we=1 wsel=3 d=16'hAAAA for one cycle -> reg3 not written (ends at CLR_VAL); wr_err pulses once, one cycle later. A second clr_req mid-sweep does not extend busy.
- Assert res at sweep cycle 2 -> next cycle all registers 0, busy=0, done never pulses.
- DEPTH=5, WIDTH=8:
  - wsel=5 write is dropped; rsel0=7 -> q0=8'h00.
  - A sweep takes 5 cycles; done on the 5th.
